fifo_rd_packer: RTL and testbench

Read-side consumer for the 16-bit-wide, 8-deep first-word-fall-through (FWFT) FIFO. It pops words whenever the FIFO is non-empty and it has room. It packs two consecutive 16-bit words into one 32-bit beat on a valid/ready output stream. A flush input emits a pending odd word as a half-filled beat. It sits between the FIFO read port and any 32-bit downstream sink.

---
 rtl/fifo_rd_packer.sv | 92 +++++++++
 tb/tb_fifo_rd_packer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_packer.sv
// Read-side consumer for a FWFT FIFO: pops 16-bit words and packs pairs into
// 32-bit valid/ready beats, with flush closing a pending odd word as a half beat.
module fifo_rd_packer #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fifo_empty,
  input  logic [WIDTH-1:0]   fifo_rdata,
  output logic               fifo_rd_en,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_data,
  output logic [1:0]         out_keep,
  output logic [15:0]        beat_count
);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_HALF,
    S_FULL
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] low_word;
  logic             fire;

  assign fire = out_valid & out_ready;

  // A presented beat only frees its slot when the sink takes it, so popping
  // in FULL is allowed exactly when the beat leaves on the same edge.
  assign fifo_rd_en = !rst && !fifo_empty && (state != S_FULL || out_ready);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_EMPTY;
      low_word   <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_keep   <= 2'b00;
      beat_count <= 16'h0000;
    end else begin
      if (fire) begin
        beat_count <= beat_count + 16'd1;
      end

      unique case (state)
        S_EMPTY: begin
          if (fifo_rd_en) begin
            low_word <= fifo_rdata;
            state    <= S_HALF;
          end
        end

        S_HALF: begin
          if (fifo_rd_en) begin
            out_data  <= {fifo_rdata, low_word};
            out_keep  <= 2'b11;
            out_valid <= 1'b1;
            state     <= S_FULL;
          end else if (flush) begin
            out_data  <= {{WIDTH{1'b0}}, low_word};
            out_keep  <= 2'b01;
            out_valid <= 1'b1;
            state     <= S_FULL;
          end
        end

        S_FULL: begin
          if (fire) begin
            out_valid <= 1'b0;
            if (fifo_rd_en) begin
              low_word <= fifo_rdata;
              state    <= S_HALF;
            end else begin
              state <= S_EMPTY;
            end
          end
        end

        default: begin
          state     <= S_EMPTY;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Self-checking bench for fifo_rd_packer: directed vector table, hand-written
// corner sequences, and randomized traffic against a queue-based reference.
module tb_fifo_rd_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        fifo_empty;
  logic [15:0] fifo_rdata;
  logic        fifo_rd_en;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_keep;
  logic [15:0] beat_count;

  always #5 clk = ~clk;

  fifo_rd_packer #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .fifo_rd_en (fifo_rd_en),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_keep   (out_keep),
    .beat_count (beat_count)
  );

  int n_pass  = 0;
  int n_total = 0;

  // FWFT FIFO in front of the DUT, 8 deep.
  logic [15:0] fifo_q[$];

  // Reference: words held by the packer, and the beat currently presented.
  logic [15:0] held[$];
  bit          m_pres;
  logic [31:0] m_data;
  logic [1:0]  m_keep;
  logic [15:0] m_count;

  typedef struct {
    bit          push_en;
    logic [15:0] push_data;
    bit          ready;
    bit          fl;
    bit          exp_rd;
    bit          exp_valid;
    logic [31:0] exp_data;
    logic [1:0]  exp_keep;
    logic [15:0] exp_count;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic sync_fifo();
    fifo_empty = (fifo_q.size() == 0);
    fifo_rdata = (fifo_q.size() != 0) ? fifo_q[0] : 16'h0000;
  endtask

  task automatic push(input logic [15:0] w);
    if (fifo_q.size() < 8) fifo_q.push_back(w);
    sync_fifo();
  endtask

  task automatic model_reset();
    held.delete();
    m_pres  = 1'b0;
    m_data  = '0;
    m_keep  = 2'b00;
    m_count = 16'h0000;
  endtask

  function automatic bit exp_rd();
    return fifo_q.size() != 0 && (!m_pres || out_ready);
  endfunction

  // Called at a falling edge: apply inputs and let combinational outputs settle.
  task automatic set_in(input bit rdy, input bit fl);
    out_ready = rdy;
    flush     = fl;
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, " rd_en"}, fifo_rd_en, exp_rd());
    check({tag, " valid"}, out_valid, m_pres);
    if (m_pres) begin
      check({tag, " data"}, out_data, m_data);
      check({tag, " keep"}, out_keep, m_keep);
    end
    check({tag, " count"}, beat_count, m_count);
  endtask

  // Advance one clock; FIFO and reference update at the next falling edge.
  task automatic tick();
    bit          dut_rd   = fifo_rd_en;
    bit          mpop     = exp_rd();
    logic [15:0] head     = fifo_rdata;
    bit          was_half = (held.size() == 1) && !m_pres;
    bit          fire     = m_pres && out_ready;
    bit          fl       = flush;
    @(posedge clk);
    @(negedge clk);
    if (dut_rd && fifo_q.size() != 0) void'(fifo_q.pop_front());
    sync_fifo();
    if (rst) begin
      model_reset();
    end else begin
      if (fire) begin
        m_count = m_count + 16'd1;
        m_pres  = 1'b0;
        held.delete();
      end
      if (mpop) held.push_back(head);
      if (held.size() == 2) begin
        m_pres = 1'b1;
        m_data = {held[1], held[0]};
        m_keep = 2'b11;
      end else if (was_half && !mpop && fl) begin
        m_pres = 1'b1;
        m_data = {16'h0000, held[0]};
        m_keep = 2'b01;
      end
    end
  endtask

  initial begin
    logic [31:0] got[$];

    //          push  data      rdy fl  rd  vld data          keep   count
    vecs[0]  = '{1'b1, 16'h1111, 1, 0, 1, 0, 32'h0,         2'b00, 16'd0};
    vecs[1]  = '{1'b1, 16'h2222, 1, 0, 1, 0, 32'h0,         2'b00, 16'd0};
    vecs[2]  = '{1'b0, 16'h0,    1, 0, 0, 1, 32'h2222_1111, 2'b11, 16'd0};
    vecs[3]  = '{1'b0, 16'h0,    1, 0, 0, 0, 32'h0,         2'b00, 16'd1};
    vecs[4]  = '{1'b1, 16'hABCD, 1, 0, 1, 0, 32'h0,         2'b00, 16'd1};
    vecs[5]  = '{1'b0, 16'h0,    1, 0, 0, 0, 32'h0,         2'b00, 16'd1};
    vecs[6]  = '{1'b0, 16'h0,    1, 0, 0, 0, 32'h0,         2'b00, 16'd1};
    vecs[7]  = '{1'b0, 16'h0,    1, 0, 0, 0, 32'h0,         2'b00, 16'd1};
    vecs[8]  = '{1'b0, 16'h0,    1, 1, 0, 0, 32'h0,         2'b00, 16'd1};
    vecs[9]  = '{1'b0, 16'h0,    0, 0, 0, 1, 32'h0000_ABCD, 2'b01, 16'd1};
    vecs[10] = '{1'b0, 16'h0,    1, 0, 0, 1, 32'h0000_ABCD, 2'b01, 16'd1};
    vecs[11] = '{1'b1, 16'h3333, 1, 0, 1, 0, 32'h0,         2'b00, 16'd2};
    vecs[12] = '{1'b1, 16'h4444, 1, 1, 1, 0, 32'h0,         2'b00, 16'd2};
    vecs[13] = '{1'b0, 16'h0,    1, 0, 0, 1, 32'h4444_3333, 2'b11, 16'd2};
    vecs[14] = '{1'b0, 16'h0,    1, 0, 0, 0, 32'h0,         2'b00, 16'd3};
    vecs[15] = '{1'b0, 16'h0,    1, 1, 0, 0, 32'h0,         2'b00, 16'd3};
    vecs[16] = '{1'b0, 16'h0,    1, 0, 0, 0, 32'h0,         2'b00, 16'd3};

    rst       = 1'b1;
    out_ready = 1'b0;
    flush     = 1'b0;
    sync_fifo();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("reset valid", out_valid, 1'b0);
    check("reset data", out_data, 32'h0);
    check("reset keep", out_keep, 2'b00);
    check("reset count", beat_count, 16'h0);
    push(16'h5A5A);
    #1;
    check("reset rd_en gated", fifo_rd_en, 1'b0);
    void'(fifo_q.pop_front());
    sync_fifo();
    rst = 1'b0;

    // Directed table: pairing, odd-word flush, flush coinciding with pop.
    for (int i = 0; i < 17; i++) begin
      if (vecs[i].push_en) push(vecs[i].push_data);
      set_in(vecs[i].ready, vecs[i].fl);
      check($sformatf("vec%0d rd_en", i), fifo_rd_en, vecs[i].exp_rd);
      check($sformatf("vec%0d valid", i), out_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) begin
        check($sformatf("vec%0d data", i), out_data, vecs[i].exp_data);
        check($sformatf("vec%0d keep", i), out_keep, vecs[i].exp_keep);
      end
      check($sformatf("vec%0d count", i), beat_count, vecs[i].exp_count);
      tick();
    end

    // Sustained stream: pop every cycle, beat every other cycle.
    for (int w = 1; w <= 8; w++) push(16'(w));
    for (int k = 0; k < 10; k++) begin
      bit exp_v;
      set_in(1'b1, 1'b0);
      exp_v = (k >= 2) && (k <= 8) && (k % 2 == 0);
      check($sformatf("sus%0d rd_en", k), fifo_rd_en, k < 8);
      check($sformatf("sus%0d valid", k), out_valid, exp_v);
      if (exp_v) check($sformatf("sus%0d data", k), out_data, {16'(k), 16'(k - 1)});
      check_model("sus");
      tick();
    end

    // Backpressure with a full FIFO, then release.
    for (int w = 1; w <= 8; w++) push(16'h0010 + 16'(w));
    for (int k = 0; k < 12; k++) begin
      set_in(1'b0, 1'b0);
      check($sformatf("bp%0d rd_en", k), fifo_rd_en, k < 2);
      if (k >= 2) begin
        check($sformatf("bp%0d valid", k), out_valid, 1'b1);
        check($sformatf("bp%0d data", k), out_data, 32'h0012_0011);
        check($sformatf("bp%0d fifo_cnt", k), fifo_q.size(), 6);
      end
      check_model("bp");
      tick();
    end
    for (int k = 0; k < 12; k++) begin
      set_in(1'b1, 1'b0);
      check_model("bp_rel");
      if (out_valid) got.push_back(out_data);
      tick();
    end
    check("bp beats", got.size(), 4);
    for (int b = 0; b < 4 && b < got.size(); b++)
      check($sformatf("bp beat%0d", b), got[b], {16'h0012 + 16'(2 * b), 16'h0011 + 16'(2 * b)});

    // Reset while HALF with the FIFO non-empty.
    push(16'hA1A1);
    push(16'hB2B2);
    set_in(1'b1, 1'b0);
    tick();
    rst = 1'b1;
    #1;
    check("midrst valid", out_valid, 1'b0);
    check("midrst data", out_data, 32'h0);
    check("midrst keep", out_keep, 2'b00);
    check("midrst count", beat_count, 16'h0);
    check("midrst rd_en", fifo_rd_en, 1'b0);
    model_reset();
    tick();
    rst = 1'b0;
    push(16'hC3C3);
    for (int k = 0; k < 4; k++) begin
      set_in(1'b1, 1'b0);
      check_model("post_rst");
      if (k == 2) check("post_rst beat", out_data, 32'hC3C3_B2B2);
      tick();
    end

    // beat_count wrap: preload to 0xFFFF, then one more beat.
    force dut.beat_count = 16'hFFFF;
    release dut.beat_count;
    m_count = 16'hFFFF;
    push(16'h0F0F);
    push(16'hF0F0);
    for (int k = 0; k < 4; k++) begin
      set_in(1'b1, 1'b0);
      check_model("wrap");
      tick();
    end
    check("wrap count", beat_count, 16'h0000);

    // Randomized traffic against the reference.
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 3) != 0) push(16'($urandom));
      set_in($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0);
      check_model("rnd");
      tick();
    end
    for (int k = 0; k < 12; k++) begin
      set_in(1'b1, 1'b1);
      check_model("drain");
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
